// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the data-RAM port arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_M0   = 2'd1,
        ARB_M1   = 2'd2
    } arb_state_t;

    localparam int HOLD_CNT_W = 4;

    // Saturating increment so a long uncontended locked run never wraps.
    function automatic logic [HOLD_CNT_W-1:0] hold_inc(input logic [HOLD_CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + HOLD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin winner pick with a bounded lock override for the owner.
module arb_rr_select
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4
)(
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_lock,
    input  logic                  i_owner_valid,
    input  logic                  i_owner,
    input  logic                  i_last_grant,
    input  logic [HOLD_CNT_W-1:0] i_hold_cnt,
    output logic                  o_winner,
    output logic                  o_valid
);

    logic w_prev;
    logic w_keep;

    // The current owner counts as the most recent grant even before last_grant updates.
    assign w_prev = i_owner_valid ? i_owner : i_last_grant;
    assign w_keep = i_owner_valid && i_req[i_owner] && i_lock[i_owner]
                    && (i_hold_cnt < HOLD_CNT_W'(HOLD_MAX));

    always_comb begin
        o_valid  = |i_req;
        o_winner = 1'b0;
        if (w_keep) begin
            o_winner = i_owner;
        end else if (&i_req) begin
            o_winner = ~w_prev;
        end else begin
            o_winner = i_req[1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for the single-port data RAM with registered read-data return.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int unsigned HOLD_MAX   = 4
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wd,
    input  logic [DATA_WIDTH-1:0] ram_rd,
    output logic                  busy
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic                  r_last_grant;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_next;
    logic [1:0]            w_req;
    logic [1:0]            w_we;
    logic [1:0]            w_lock;
    logic [1:0]            w_gnt;
    logic                  w_owner_valid;
    logic                  w_owner;
    logic                  w_sel_winner;
    logic                  w_sel_valid;

    assign w_req         = {m1_req, m0_req};
    assign w_we          = {m1_we, m0_we};
    assign w_lock        = {m1_lock, m0_lock};
    assign w_owner_valid = (r_state != ARB_IDLE);
    assign w_owner       = (r_state == ARB_M1);

    arb_rr_select #(
        .HOLD_MAX (HOLD_MAX)
    ) u_select (
        .i_req         (w_req),
        .i_lock        (w_lock),
        .i_owner_valid (w_owner_valid),
        .i_owner       (w_owner),
        .i_last_grant  (r_last_grant),
        .i_hold_cnt    (r_hold_cnt),
        .o_winner      (w_sel_winner),
        .o_valid       (w_sel_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
            r_hold_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            if (w_owner_valid) begin
                r_last_grant <= w_owner;
            end
        end
    end

    // A slot whose owner has already dropped req performs no access and raises no gnt.
    always_comb begin
        w_state_next = ARB_IDLE;
        w_hold_next  = '0;
        w_gnt        = '0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wd       = '0;
        if (w_sel_valid) begin
            w_state_next = w_sel_winner ? ARB_M1 : ARB_M0;
        end
        if (w_owner_valid && w_sel_valid && (w_sel_winner == w_owner)) begin
            w_hold_next = hold_inc(r_hold_cnt);
        end
        case (r_state)
            ARB_M0: begin
                ram_addr = m0_addr;
                ram_wd   = m0_wdata;
                ram_we   = m0_we & m0_req;
                w_gnt[0] = m0_req;
            end
            ARB_M1: begin
                ram_addr = m1_addr;
                ram_wd   = m1_wdata;
                ram_we   = m1_we & m1_req;
                w_gnt[1] = m1_req;
            end
            default: begin
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic                  r_rvalid;
        logic [DATA_WIDTH-1:0] r_rdata;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= w_gnt[gi] & ~w_we[gi];
                if (w_gnt[gi] && !w_we[gi]) begin
                    r_rdata <= ram_rd;
                end
            end
        end
    end

    assign m0_gnt    = w_gnt[0];
    assign m1_gnt    = w_gnt[1];
    assign m0_rvalid = g_port[0].r_rvalid;
    assign m1_rvalid = g_port[1].r_rvalid;
    assign m0_rdata  = g_port[0].r_rdata;
    assign m1_rdata  = g_port[1].r_rdata;
    assign busy      = w_owner_valid;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised scoreboard bench for ram_port_arbiter with a slot-level arbitration model.
module tb_ram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int HM = 4;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req [2];
    logic          we [2];
    logic          lock [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wd;
    logic [DW-1:0] ram_rd;
    logic          busy;

    logic [31:0]   mem [256];
    logic [31:0]   ref_mem [256];
    rexp_t         rq [2][$];
    logic          seen_gnt [2];
    int            gcnt [2];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            model_en = 1'b0;
    int            slot;
    int            last_served;
    int            streak;

    ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .HOLD_MAX   (HM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_lock   (lock[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_lock   (lock[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wd    (ram_wd),
        .ram_rd    (ram_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM instance: asynchronous read, write on the rising edge.
    assign ram_rd = mem[ram_addr[7:0]];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:0]] <= ram_wd;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_init();
        slot        = -1;
        last_served = 1;
        streak      = 0;
        rq[0].delete();
        rq[1].delete();
    endtask

    // Reference: each cycle belongs to a slot (none, M0 or M1); the slot owner with req high is served.
    always @(negedge clk) begin : model_blk
        int prev;
        int nxt;
        logic exp_g;
        seen_gnt[0] = m0_gnt;
        seen_gnt[1] = m1_gnt;
        if (m0_gnt) gcnt[0]++;
        if (m1_gnt) gcnt[1]++;
        if (model_en) begin
            exp_g = (slot == 0) && req[0];
            check("m0_gnt", m0_gnt, exp_g);
            exp_g = (slot == 1) && req[1];
            check("m1_gnt", m1_gnt, exp_g);
            check("busy", busy, slot >= 0);
            if (slot >= 0) begin
                check("ram_we", ram_we, req[slot] && we[slot]);
                check("ram_addr", ram_addr, addr[slot]);
                if (req[slot]) begin
                    if (we[slot]) ref_mem[addr[slot][7:0]] = wdata[slot];
                    else rq[slot].push_back('{cyc + 1, ref_mem[addr[slot][7:0]]});
                end
            end else begin
                check("ram_we_idle", ram_we, 1'b0);
            end
            prev = (slot >= 0) ? slot : last_served;
            if (slot >= 0 && req[slot] && lock[slot] && streak < HM) nxt = slot;
            else if (req[0] && req[1]) nxt = 1 - prev;
            else if (req[0]) nxt = 0;
            else if (req[1]) nxt = 1;
            else nxt = -1;
            if (slot >= 0) last_served = slot;
            if (nxt >= 0 && nxt == slot) streak = (streak < 15) ? streak + 1 : 15;
            else streak = 0;
            slot = nxt;
        end
    end

    // Monitor: every rvalid must match the oldest outstanding read of that master, one cycle after its grant.
    always @(negedge clk) begin : mon_blk
        logic        rv;
        logic [31:0] rd;
        if (model_en) begin
            for (int x = 0; x < 2; x++) begin
                rv = (x == 0) ? m0_rvalid : m1_rvalid;
                rd = (x == 0) ? m0_rdata : m1_rdata;
                if (rq[x].size() > 0 && rq[x][0].due == cyc) begin
                    check((x == 0) ? "m0_rvalid" : "m1_rvalid", rv, 1'b1);
                    check((x == 0) ? "m0_rdata" : "m1_rdata", rd, rq[x][0].data);
                    void'(rq[x].pop_front());
                end else begin
                    check((x == 0) ? "m0_rvalid_quiet" : "m1_rvalid_quiet", rv, 1'b0);
                end
            end
        end
    end

    task automatic new_req(input int x, input int lockmode);
        req[x]   = 1'b1;
        we[x]    = 1'($urandom_range(0, 1));
        addr[x]  = $urandom_range(0, 15) * 4;
        wdata[x] = $urandom;
        lock[x]  = (lockmode == 2) ? 1'($urandom_range(0, 1)) : 1'(lockmode);
    endtask

    task automatic drive(input int x, input int pct, input int lockmode);
        if (req[x] && !seen_gnt[x]) return;
        if ($urandom_range(0, 99) < pct) new_req(x, lockmode);
        else begin
            req[x]  = 1'b0;
            lock[x] = 1'b0;
        end
    endtask

    task automatic run(input int n, input int p0, input int l0, input int p1, input int l1);
        repeat (n) begin
            @(posedge clk); #1;
            drive(0, p0, l0);
            drive(1, p1, l1);
        end
    endtask

    task automatic idle(input int n);
        for (int x = 0; x < 2; x++) begin
            req[x]  = 1'b0;
            lock[x] = 1'b0;
        end
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic issue(input int x, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[x]   = 1'b1;
        we[x]    = w;
        lock[x]  = 1'b0;
        addr[x]  = a;
        wdata[x] = d;
    endtask

    task automatic wait_gnt(input int x, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!seen_gnt[x] && n < 20);
        check((x == 0) ? "m0_gnt_seen" : "m1_gnt_seen", seen_gnt[x], 1'b1);
    endtask

    initial begin
        int          n;
        int          g0;
        logic [31:0] orig;
        logic        got;
        rst = 1'b1;
        for (int x = 0; x < 2; x++) begin
            req[x] = 1'b0; we[x] = 1'b0; lock[x] = 1'b0;
            addr[x] = '0; wdata[x] = '0; seen_gnt[x] = 1'b0; gcnt[x] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= 32'hC0DE_0000 | i;
            ref_mem[i]  = 32'hC0DE_0000 | i;
        end
        mem[8'h04]     <= 32'h1234_5678;
        ref_mem[8'h04]  = 32'h1234_5678;
        model_init();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m0_gnt", m0_gnt, 1'b0);
        check("rst_m1_gnt", m1_gnt, 1'b0);
        check("rst_m0_rvalid", m0_rvalid, 1'b0);
        check("rst_m1_rvalid", m1_rvalid, 1'b0);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        rst = 1'b1;
        model_init();
        model_en = 1'b1;

        // Single read from idle: gnt one cycle after req, data the cycle after that.
        issue(0, 1'b0, 32'h04, 32'h0);
        wait_gnt(0, n);
        check("read_gnt_latency", n, 2);
        req[0] = 1'b0;
        check("read_rvalid", m0_rvalid, 1'b1);
        check("read_rdata", m0_rdata, 32'h1234_5678);
        idle(3);

        run(10, 100, 0, 100, 0);          // continuous contention
        idle(2);
        run(16, 100, 1, 100, 0);          // M0 locked while M1 waits
        idle(2);
        g0 = gcnt[0];
        run(22, 100, 1, 0, 0);            // M0 locked alone
        check("lock_alone_grants", gcnt[0] - g0, 20);
        idle(2);

        // M1 writes, then M0 reads the same word back.
        issue(1, 1'b1, 32'h08, 32'hA5A5_0001);
        wait_gnt(1, n);
        req[1] = 1'b0;
        issue(0, 1'b0, 32'h08, 32'h0);
        wait_gnt(0, n);
        req[0] = 1'b0;
        check("wr_rd_rdata", m0_rdata, 32'hA5A5_0001);
        idle(3);

        run(1500, 60, 2, 60, 2);
        idle(4);

        // Reset asserted in the middle of an M0 write grant.
        model_en = 1'b0;
        orig = mem[8'h10];
        issue(0, 1'b1, 32'h10, 32'h0000_DEAD);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = m0_gnt;
        end
        check("midwrite_gnt_seen", got, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midwrite_ram_we", ram_we, 1'b0);
        check("midwrite_m0_gnt", m0_gnt, 1'b0);
        check("midwrite_busy", busy, 1'b0);
        check("midwrite_m0_rdata", m0_rdata, 32'h0);
        check("midwrite_m1_rdata", m1_rdata, 32'h0);
        check("midwrite_m0_rvalid", m0_rvalid, 1'b0);
        @(posedge clk); #1;
        check("midwrite_mem", mem[8'h10], orig);
        req[0] = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter sharing the single-port data RAM (async read, sync write) between the RISC-V core (M0) and a UART DMA/bridge engine (M1).
- Sits between the memory map controller's RAM-side signals and the RAM instance.
- Round-robin selection, optional lock for atomic back-to-back sequences, registered read-data return with a valid pulse.

Parameters:
DATA_WIDTH, 32, width of write/read data
ADDR_WIDTH, 32, width of requester and RAM addresses
HOLD_MAX, 4, max consecutive locked grants to one master while the other is waiting (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
m0_req  in  1  M0 access request; held until m0_gnt seen
m0_we  in  1  M0 write (1) / read (0)
m0_lock  in  1  M0 requests keeping the grant for its next access
m0_addr  in  ADDR_WIDTH  M0 address
m0_wdata  in  DATA_WIDTH  M0 write data
m0_gnt  out  1  M0 access performed this cycle
m0_rvalid  out  1  M0 read data valid (one-cycle pulse)
m0_rdata  out  DATA_WIDTH  M0 registered read data
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as M0, for M1
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wd  out  DATA_WIDTH  RAM write data
ram_rd  in  DATA_WIDTH  RAM read data (combinational)
busy  out  1  state != ARB_IDLE

Behaviour:
- FSM states: ARB_IDLE, ARB_M0, ARB_M1. Register last_grant (reset 1, so M0 wins the first tie) and hold_cnt (4 bits, reset 0).
- Reset (rst=0, async): state ARB_IDLE; all gnt/rvalid 0; rdata 0; hold_cnt 0. ram_we is decoded from state, so it drops immediately. A write in flight at reset assertion never commits.
- Winner selection (both IDLE and ARB_Mx exit):
  - Only one req high: that master wins.
  - Both high: the master != last_grant wins.
  - Lock override: if the current owner has lock=1 and req=1 and hold_cnt < HOLD_MAX, the owner keeps the grant.
  - No req: go to ARB_IDLE.
- ARB_IDLE: no RAM drive (ram_we=0, ram_addr/ram_wd = 0). Next state = winner.
- ARB_Mx, in the same cycle:
  - ram_addr/ram_wd/ram_we = mx_addr/mx_wdata/mx_we; mx_gnt=1.
  - last_grant <= x.
  - hold_cnt <= hold_cnt+1 if the same master is re-granted, else 0 (saturates at 15).
  - Write commits at the clock edge ending the cycle.
- Latency:
  - Request to gnt: 1 cycle from IDLE; 0 extra cycles when queued behind another grant.
  - Back-to-back throughput: 1 access per cycle.
- Read return: on a read grant, mx_rdata <= ram_rd at the end of the grant cycle; mx_rvalid=1 for exactly the following cycle. rdata holds its value until the next read by that master. Write grants produce no rvalid.
- Handshake: a master keeps req/we/addr/wdata stable until it samples gnt=1. It deasserts req or presents a new request the cycle after gnt. A req still high after gnt is treated as a new request.
- Lock rules:
  - Lock is honoured only while req stays high.
  - After HOLD_MAX consecutive re-grants with the other master waiting, the grant passes to the other master.
  - If the other master is not waiting, the owner continues and hold_cnt saturates without forcing a handover.
- Simultaneous events: a new req arriving in the same cycle as the other's grant waits; it is served next cycle. A master's rvalid and a new gnt for the same master may coincide.
- Only one gnt is high per cycle; gnt is never asserted without the matching req.

Decomposition:
- Arbiter_pkg: typedef enum arb_state_t {ARB_IDLE, ARB_M0, ARB_M1}; localparam HOLD_CNT_W = 4.
- One sub-module: arb_rr_select, combinational winner pick from req[1:0], lock, last_grant, hold_cnt, HOLD_MAX → winner, valid.

Test Plan:
- Reset mid-write: M0 write addr 0x10 data 0xDEAD in ARB_M0, rst low same cycle → ram_we 0 immediately; RAM[0x10] unchanged; all outputs at reset values.
- Single read: M0 read addr 0x04 (RAM=0x1234_5678) from IDLE → m0_gnt in cycle 1; m0_rvalid in cycle 2 with m0_rdata 0x1234_5678.
- Contention: both req from reset, continuously → grants alternate M0, M1, M0, M1 each cycle; never both gnt.
- Lock + starvation: M0 lock=1 continuously, M1 req held, HOLD_MAX=4 → M0 gets the initial grant plus 4 consecutive re-grants, then M1 gets a grant, then M0 again.
- Lock without contention: M0 lock=1, M1 idle, 20 requests → 20 consecutive M0 grants; hold_cnt saturates at 15.
- Write then read same address: M1 write 0xA5A5_0001 to 0x08, then M0 read 0x08 → m0_rdata 0xA5A5_0001; m1_rvalid never asserted.
